pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline-stage register for the RV32IM pipeline, a successor to the fixed-field inter-stage latches. It carries an arbitrary-width payload and a separately-clearable control field between two stages using a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered IN_READY. It also supports flush-to-bubble and has saturating stall and flush performance counters for the hazard unit and the debug bus.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
//   occ_e       : occupancy/FSM state encoding (EMPTY, ONE, FULL)
//   *_W_DEFAULT : default payload, control and counter widths
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 128;
  localparam int unsigned CTRL_W_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance statistics.
//   CLK     : clock, rising edge
//   RESET_N : asynchronous active-low reset, clears COUNT
//   INC     : count this cycle
//   COUNT   : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
    end else if (INC && (COUNT != '1)) begin
      COUNT <= COUNT + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// Main register drives OUT_*, skid register absorbs the transfer accepted
// in the cycle the stage fills, so IN_READY can be registered.
//   CLK, RESET_N        : clock, asynchronous active-low reset
//   FLUSH               : synchronous flush to bubble (drops held entries)
//   IN_VALID/IN_READY   : upstream handshake, IN_READY registered
//   IN_DATA/IN_CTRL     : upstream payload and control
//   OUT_VALID/OUT_READY : downstream handshake
//   OUT_DATA/OUT_CTRL   : head entry, OUT_CTRL is zero while no entry is held
//   OCCUPANCY           : entries held (0..2)
//   STALL_CNT/FLUSH_CNT : saturating stall and flush cycle counters
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  occ_e              state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  logic accept, rel;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign OUT_VALID = (state_q != EMPTY);
  assign IN_READY  = in_ready_q;
  assign accept    = IN_VALID & in_ready_q;
  assign rel       = OUT_VALID & OUT_READY;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && rel) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (rel) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rel) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any accept in the same cycle; a concurrent release
    // has already been taken by downstream and needs no action here.
    if (FLUSH) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_data_q <= IN_DATA;
      end else if (ld_main_skid) begin
        main_data_q <= skid_data_q;
      end
      if (ld_skid) begin
        skid_data_q <= IN_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else if (FLUSH) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl_q <= IN_CTRL;
      end else if (ld_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
      end
      if (ld_skid) begin
        skid_ctrl_q <= IN_CTRL;
      end
    end
  end

  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = OUT_VALID ? main_ctrl_q : '0;
  assign OCCUPANCY = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .INC     (OUT_VALID & ~OUT_READY),
    .COUNT   (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .INC     (FLUSH),
    .COUNT   (FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic [CW-1:0] IN_CTRL;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic [CW-1:0] OUT_CTRL;
  logic [1:0]    OCCUPANCY;
  logic [NW-1:0] STALL_CNT;
  logic [NW-1:0] FLUSH_CNT;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW+CW-1:0] exp_q[$];

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_CTRL   (IN_CTRL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_CTRL  (OUT_CTRL),
    .OCCUPANCY (OCCUPANCY),
    .STALL_CNT (STALL_CNT),
    .FLUSH_CNT (FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every downstream transfer pops one expected entry.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got data %0h ctrl %0h expected no transfer", OUT_DATA, OUT_CTRL);
        end else begin
          logic [DW+CW-1:0] e;
          e = exp_q.pop_front();
          if ({OUT_DATA, OUT_CTRL} !== e) begin
            errors++;
            $display("FAIL sb_out: got %0h/%0h expected %0h/%0h",
                     OUT_DATA, OUT_CTRL, e[DW+CW-1:CW], e[CW-1:0]);
          end
        end
      end
      if (!OUT_VALID) chk("bubble_ctrl", 64'(OUT_CTRL), 64'h0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    IN_VALID = v;
    IN_DATA  = d;
    IN_CTRL  = c;
  endtask

  task automatic expect_item(input logic [DW-1:0] d, input logic [CW-1:0] c);
    exp_q.push_back({d, c});
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    FLUSH = 1'b0;
    OUT_READY = 1'b0;
    drive(1'b0, '0, '0);
    exp_q.delete();
    step();
    step();
    RESET_N = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset values
    chk("rst_out_valid", 64'(OUT_VALID), 64'h0);
    chk("rst_in_ready",  64'(IN_READY),  64'h1);
    chk("rst_occ",       64'(OCCUPANCY), 64'h0);
    chk("rst_out_data",  64'(OUT_DATA),  64'h0);
    chk("rst_out_ctrl",  64'(OUT_CTRL),  64'h0);
    chk("rst_stall",     64'(STALL_CNT), 64'h0);
    chk("rst_flush",     64'(FLUSH_CNT), 64'h0);

    // Streaming 1..8 at full throughput
    OUT_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(8'h10 + i));
      expect_item(DW'(i), CW'(8'h10 + i));
      step();
      if (i == 1) begin
        chk("lat_valid", 64'(OUT_VALID), 64'h1);
        chk("lat_data",  64'(OUT_DATA),  64'h1);
        chk("lat_ctrl",  64'(OUT_CTRL),  64'h11);
      end
      if (i > 1) chk("stream_ready", 64'(IN_READY), 64'h1);
    end
    drive(1'b0, '0, '0);
    step();
    step();
    chk("stream_drained", 64'(exp_q.size()), 64'h0);
    chk("stream_stall",   64'(STALL_CNT),    64'h0);
    chk("stream_occ",     64'(OCCUPANCY),    64'h0);

    // Backpressure: A, B held, C waits
    do_reset();
    drive(1'b1, 32'hA, 8'hA1);
    expect_item(32'hA, 8'hA1);
    step();
    chk("bp_occ1", 64'(OCCUPANCY), 64'h1);
    drive(1'b1, 32'hB, 8'hB2);
    expect_item(32'hB, 8'hB2);
    step();
    chk("bp_occ2",   64'(OCCUPANCY), 64'h2);
    chk("bp_ready0", 64'(IN_READY),  64'h0);
    chk("bp_head",   64'(OUT_DATA),  64'hA);
    drive(1'b1, 32'hC, 8'hC3);
    expect_item(32'hC, 8'hC3);
    step();
    step();
    chk("bp_hold_occ", 64'(OCCUPANCY), 64'h2);
    chk("bp_hold_head", 64'(OUT_DATA), 64'hA);
    chk("bp_stall3",   64'(STALL_CNT), 64'h3);
    OUT_READY = 1'b1;
    step();
    chk("bp_ready1", 64'(IN_READY), 64'h1);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("bp_occ_end",   64'(OCCUPANCY),    64'h0);
    chk("bp_stall_end", 64'(STALL_CNT),    64'h3);
    chk("bp_drained",   64'(exp_q.size()), 64'h0);

    // Flush while FULL with D offered
    do_reset();
    drive(1'b1, 32'hA, 8'hFF);
    step();
    drive(1'b1, 32'hB, 8'hFE);
    step();
    drive(1'b1, 32'hD, 8'hDD);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl_valid", 64'(OUT_VALID), 64'h0);
    chk("fl_ctrl",  64'(OUT_CTRL),  64'h0);
    chk("fl_occ",   64'(OCCUPANCY), 64'h0);
    chk("fl_ready", 64'(IN_READY),  64'h1);
    chk("fl_cnt",   64'(FLUSH_CNT), 64'h1);
    drive(1'b0, '0, '0);
    OUT_READY = 1'b1;
    step();
    step();
    chk("fl_d_dropped", 64'(OUT_VALID), 64'h0);

    // Flush coincident with release of A, plus a discarded accept of E
    do_reset();
    drive(1'b1, 32'hA, 8'h3C);
    expect_item(32'hA, 8'h3C);
    step();
    OUT_READY = 1'b1;
    FLUSH = 1'b1;
    drive(1'b1, 32'hE, 8'hEE);
    step();
    FLUSH = 1'b0;
    drive(1'b0, '0, '0);
    chk("flr_occ",   64'(OCCUPANCY),    64'h0);
    chk("flr_valid", 64'(OUT_VALID),    64'h0);
    chk("flr_cnt",   64'(FLUSH_CNT),    64'h1);
    chk("flr_once",  64'(exp_q.size()), 64'h0);
    step();
    step();
    chk("flr_empty", 64'(OUT_VALID), 64'h0);

    // Asynchronous reset mid-stream with two entries held
    do_reset();
    drive(1'b1, 32'h11, 8'h81);
    step();
    drive(1'b1, 32'h22, 8'h82);
    step();
    drive(1'b0, '0, '0);
    FLUSH = 1'b0;
    step();
    chk("mr_pre_occ", 64'(OCCUPANCY), 64'h2);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mr_valid", 64'(OUT_VALID), 64'h0);
    chk("mr_ctrl",  64'(OUT_CTRL),  64'h0);
    chk("mr_occ",   64'(OCCUPANCY), 64'h0);
    chk("mr_ready", 64'(IN_READY),  64'h1);
    chk("mr_stall", 64'(STALL_CNT), 64'h0);
    chk("mr_flush", 64'(FLUSH_CNT), 64'h0);
    exp_q.delete();
    #1;
    RESET_N = 1'b1;
    OUT_READY = 1'b1;
    drive(1'b1, 32'h5EED, 8'h77);
    expect_item(32'h5EED, 8'h77);
    step();
    drive(1'b0, '0, '0);
    chk("mr_first_valid", 64'(OUT_VALID), 64'h1);
    chk("mr_first_data",  64'(OUT_DATA),  64'h5EED);
    step();

    // Stall counter saturation (4-bit)
    do_reset();
    drive(1'b1, 32'h99, 8'h09);
    expect_item(32'h99, 8'h09);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", 64'(STALL_CNT), 64'hF);
    step();
    step();
    chk("sat_hold", 64'(STALL_CNT), 64'hF);
    OUT_READY = 1'b1;
    step();
    step();
    chk("sat_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
